// File: rtl/mic_period_meter.sv
// mic_period_meter
// Measures the period of the asynchronous mic_clk square wave in clk cycles
// and averages it over 2^AVG_LOG2 consecutive periods. A sticky timeout flag
// reports a stalled or absent sensor.
module mic_period_meter #(
    parameter int CNT_W    = 24,
    parameter int AVG_LOG2 = 4,
    parameter int TIMEOUT  = 2_000_000
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      mic_clk,
    input  logic                      enable,
    output logic [CNT_W+AVG_LOG2-1:0] period_sum,
    output logic [CNT_W-1:0]          period_avg,
    output logic                      meas_valid,
    output logic                      timeout
);

    localparam int                  SUM_W     = CNT_W + AVG_LOG2;
    localparam logic [CNT_W-1:0]    TIMEOUT_C = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0]    CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0]    CNT_ZERO  = {CNT_W{1'b0}};
    localparam logic [SUM_W-1:0]    ACC_ZERO  = {SUM_W{1'b0}};
    localparam logic [AVG_LOG2-1:0] IDX_ZERO  = {AVG_LOG2{1'b0}};
    localparam logic [AVG_LOG2-1:0] IDX_ONE   = AVG_LOG2'(1);
    localparam logic [AVG_LOG2-1:0] IDX_LAST  = {AVG_LOG2{1'b1}};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ARM  = 2'd1,
        ST_MEAS = 2'd2
    } state_t;

    state_t              state_r;
    logic                sync1_r;
    logic                sync2_r;
    logic                sync3_r;
    logic [CNT_W-1:0]    pcnt_r;
    logic [SUM_W-1:0]    acc_r;
    logic [AVG_LOG2-1:0] idx_r;

    logic                rise_s;
    logic                at_limit_s;
    logic [SUM_W-1:0]    sum_next_s;

    // Two-flop synchronizer plus one delay flop for rising-edge detection
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_r <= 1'b0;
            sync2_r <= 1'b0;
            sync3_r <= 1'b0;
        end else begin
            sync1_r <= mic_clk;
            sync2_r <= sync1_r;
            sync3_r <= sync2_r;
        end
    end

    // Edge strobe, timeout comparison and the running sum including the current sample
    always_comb begin
        rise_s     = sync2_r & ~sync3_r;
        at_limit_s = (pcnt_r == TIMEOUT_C);
        sum_next_s = acc_r + {{AVG_LOG2{1'b0}}, pcnt_r};
    end

    // Arm/measure controller with period counter, accumulator and registered outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r    <= ST_IDLE;
            pcnt_r     <= CNT_ZERO;
            acc_r      <= ACC_ZERO;
            idx_r      <= IDX_ZERO;
            period_sum <= ACC_ZERO;
            period_avg <= CNT_ZERO;
            meas_valid <= 1'b0;
            timeout    <= 1'b0;
        end else begin
            meas_valid <= 1'b0;
            if (!enable) begin
                // Disabled: drop any partial window, keep the published results
                state_r <= ST_IDLE;
                pcnt_r  <= CNT_ONE;
                acc_r   <= ACC_ZERO;
                idx_r   <= IDX_ZERO;
            end else begin
                case (state_r)
                    ST_IDLE: begin
                        state_r <= ST_ARM;
                        pcnt_r  <= CNT_ONE;
                        acc_r   <= ACC_ZERO;
                        idx_r   <= IDX_ZERO;
                    end
                    ST_ARM: begin
                        // First edge only starts the period count; it yields no sample
                        if (rise_s) begin
                            state_r <= ST_MEAS;
                            pcnt_r  <= CNT_ONE;
                        end else if (at_limit_s) begin
                            timeout <= 1'b1;
                            pcnt_r  <= CNT_ONE;
                        end else begin
                            pcnt_r <= pcnt_r + CNT_ONE;
                        end
                    end
                    ST_MEAS: begin
                        // An edge takes priority over a coincident timeout
                        if (rise_s) begin
                            pcnt_r <= CNT_ONE;
                            if (idx_r == IDX_LAST) begin
                                period_sum <= sum_next_s;
                                period_avg <= sum_next_s[SUM_W-1:AVG_LOG2];
                                meas_valid <= 1'b1;
                                timeout    <= 1'b0;
                                acc_r      <= ACC_ZERO;
                                idx_r      <= IDX_ZERO;
                            end else begin
                                acc_r <= sum_next_s;
                                idx_r <= idx_r + IDX_ONE;
                            end
                        end else if (at_limit_s) begin
                            timeout <= 1'b1;
                            state_r <= ST_ARM;
                            pcnt_r  <= CNT_ONE;
                            acc_r   <= ACC_ZERO;
                            idx_r   <= IDX_ZERO;
                        end else begin
                            pcnt_r <= pcnt_r + CNT_ONE;
                        end
                    end
                    default: begin
                        state_r <= ST_IDLE;
                        pcnt_r  <= CNT_ONE;
                        acc_r   <= ACC_ZERO;
                        idx_r   <= IDX_ZERO;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_mic_period_meter.sv
// Testbench for mic_period_meter: a stimulus-timing model predicts each
// averaging window and pushes it to a scoreboard queue that a monitor pops
// on every meas_valid; directed sequences cover timeout, enable and reset.
module tb_mic_period_meter;

    localparam int CNT_W    = 24;
    localparam int AVG_LOG2 = 4;
    localparam int TIMEOUT  = 5000;
    localparam int SUM_W    = CNT_W + AVG_LOG2;
    localparam int NWIN     = 16;

    logic             clk;
    logic             rst;
    logic             mic_clk;
    logic             enable;
    logic [SUM_W-1:0] period_sum;
    logic [CNT_W-1:0] period_avg;
    logic             meas_valid;
    logic             timeout;

    mic_period_meter #(
        .CNT_W(CNT_W),
        .AVG_LOG2(AVG_LOG2),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .mic_clk(mic_clk),
        .enable(enable),
        .period_sum(period_sum),
        .period_avg(period_avg),
        .meas_valid(meas_valid),
        .timeout(timeout)
    );

    typedef struct {
        longint sum;
        longint avg;
    } exp_t;

    typedef struct {
        int     hi;
        int     lo;
        longint sum;
        longint avg;
        int     spacing;
    } vec_t;

    exp_t   sb_q[$];
    vec_t   vecs[4];

    int     checks = 0;
    int     failures = 0;
    int     cyc = 0;

    // stimulus generator state
    int     hi_cyc = 563;
    int     lo_cyc = 563;
    int     ph_cnt = 0;
    bit     mic_run = 1'b0;
    int     rise_cnt = 0;
    event   mic_rose;
    event   mic_fell;

    // reference model state
    bit     model_en = 1'b0;
    bit     model_armed = 1'b0;
    int     model_n = 0;
    longint model_acc = 0;
    int     model_last = 0;
    longint last_exp_sum = 0;
    longint last_exp_avg = 0;

    // monitor state
    int               valid_cnt = 0;
    int               valid_cyc = 0;
    int               prev_valid_cyc = 0;
    int               rise_at_valid = 0;
    bit               prev_valid = 1'b0;
    logic [SUM_W-1:0] obs_sum = '0;
    logic [CNT_W-1:0] obs_avg = '0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        forever begin
            @(posedge clk);
            cyc = cyc + 1;
        end
    end

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", name, act, exp);
        end
    endtask

    task automatic check_true(string name, bit cond, longint act);
        checks++;
        if (!cond) begin
            failures++;
            $display("FAIL %s got=%0d", name, act);
        end
    endtask

    task automatic model_reset();
        model_armed = 1'b0;
        model_n     = 0;
        model_acc   = 0;
    endtask

    // Rising edge of mic_clk at cycle c: first one arms, later ones are samples
    task automatic model_rise(int c);
        exp_t e;
        if (model_en) begin
            if (model_armed) begin
                model_acc += longint'(c - model_last);
                model_n++;
                if (model_n == NWIN) begin
                    e.sum = model_acc;
                    e.avg = model_acc >> AVG_LOG2;
                    sb_q.push_back(e);
                    last_exp_sum = e.sum;
                    last_exp_avg = e.avg;
                    model_acc = 0;
                    model_n   = 0;
                end
            end
            model_armed = 1'b1;
            model_last  = c;
        end
    endtask

    // mic_clk generator: high for hi_cyc and low for lo_cyc clk cycles
    initial begin
        mic_clk = 1'b0;
        forever begin
            @(negedge clk);
            if (mic_run) begin
                ph_cnt++;
                if (ph_cnt >= (mic_clk ? hi_cyc : lo_cyc)) begin
                    ph_cnt  = 0;
                    mic_clk = ~mic_clk;
                    if (mic_clk) begin
                        rise_cnt++;
                        model_rise(cyc);
                        -> mic_rose;
                    end else begin
                        -> mic_fell;
                    end
                end
            end
        end
    end

    // Output monitor: pops the scoreboard on every meas_valid
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst === 1'b1 && meas_valid === 1'b1) begin
                valid_cnt++;
                prev_valid_cyc = valid_cyc;
                valid_cyc      = cyc;
                rise_at_valid  = rise_cnt;
                obs_sum        = period_sum;
                obs_avg        = period_avg;
                check("valid_one_cycle", {63'd0, prev_valid}, 64'd0);
                if (sb_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL sb_unexpected_valid got_sum=%0d exp=none", period_sum);
                end else begin
                    e = sb_q.pop_front();
                    check("sb_sum", period_sum, e.sum);
                    check("sb_avg", period_avg, e.avg);
                end
            end
            prev_valid = (meas_valid === 1'b1);
        end
    end

    task automatic wait_cycles(int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic set_enable(bit v);
        enable   = v;
        model_en = v;
        model_reset();
    endtask

    task automatic start_mic(int h, int l);
        hi_cyc   = h;
        lo_cyc   = l;
        mic_clk  = 1'b0;
        ph_cnt   = 0;
        rise_cnt = 0;
        mic_run  = 1'b1;
    endtask

    task automatic stop_mic_low();
        mic_run = 1'b0;
        mic_clk = 1'b0;
    endtask

    task automatic wait_valids(int target, int budget, string name);
        int n = 0;
        while (valid_cnt < target && n < budget) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (valid_cnt < target) begin
            failures++;
            $display("FAIL %s_wait got_valids=%0d exp=%0d", name, valid_cnt, target);
        end
    endtask

    // Global watchdog
    initial begin
        #(2_000_000);
        $display("FAIL watchdog got=stuck exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        int vc;
        longint hold_sum;
        longint hold_avg;

        vecs[0] = '{hi: 2,  lo: 2,  sum: 64,  avg: 4,  spacing: 64};
        vecs[1] = '{hi: 3,  lo: 3,  sum: 96,  avg: 6,  spacing: 96};
        vecs[2] = '{hi: 2,  lo: 5,  sum: 112, avg: 7,  spacing: 112};
        vecs[3] = '{hi: 20, lo: 30, sum: 800, avg: 50, spacing: 800};

        // reset state
        rst    = 1'b0;
        enable = 1'b0;
        wait_cycles(3);
        check("rst_sum", period_sum, 64'd0);
        check("rst_avg", period_avg, 64'd0);
        check("rst_valid", {63'd0, meas_valid}, 64'd0);
        check("rst_timeout", {63'd0, timeout}, 64'd0);
        rst = 1'b1;
        wait_cycles(2);

        // steady 1126-cycle period
        set_enable(1'b1);
        wait_cycles(5);
        start_mic(563, 563);
        wait_valids(1, 20000, "steady");
        check("steady_edges", rise_at_valid, 64'd17);
        check("steady_sum", obs_sum, 64'd18016);
        check("steady_avg", obs_avg, 64'd1126);

        // frequency step to 1346 midway through the next window
        repeat (8) @(mic_rose);
        hi_cyc = 673;
        lo_cyc = 673;
        wait_valids(2, 25000, "mixed");
        check_true("mixed_avg_range", obs_avg > 1126 && obs_avg < 1346, obs_avg);
        wait_valids(3, 25000, "step");
        check("step_sum", obs_sum, 64'd21536);
        check("step_avg", obs_avg, 64'd1346);
        check("step_spacing", valid_cyc - prev_valid_cyc, 64'd21536);

        // timeout: mic_clk stops high
        @(mic_rose);
        mic_run = 1'b0;
        vc = valid_cnt;
        n  = 0;
        while (timeout !== 1'b1 && n < TIMEOUT + 50) begin
            @(negedge clk);
            n++;
        end
        check("timeout_latency", n, TIMEOUT + 3);
        check("timeout_no_valid", valid_cnt, vc);
        model_reset();
        start_mic(100, 100);
        wait_cycles(50);
        check("timeout_sticky", {63'd0, timeout}, 64'd1);
        wait_valids(vc + 1, 6000, "restart");
        check("restart_timeout_clr", {63'd0, timeout}, 64'd0);
        check("restart_edges", rise_at_valid, 64'd17);
        check("restart_avg", obs_avg, 64'd200);

        // enable dropped mid-window, then restored
        repeat (8) @(mic_rose);
        wait_cycles(10);
        hold_sum = last_exp_sum;
        hold_avg = last_exp_avg;
        vc = valid_cnt;
        set_enable(1'b0);
        wait_cycles(1000);
        check("dis_no_valid", valid_cnt, vc);
        check("dis_hold_sum", period_sum, hold_sum);
        check("dis_hold_avg", period_avg, hold_avg);
        check("dis_hold_timeout", {63'd0, timeout}, 64'd0);
        @(mic_rose);
        wait_cycles(10);
        rise_cnt = 0;
        set_enable(1'b1);
        wait_valids(vc + 1, 4000, "reenable");
        check("reen_edges", rise_at_valid, 64'd17);
        check("reen_sum", obs_sum, 64'd3200);
        check("reen_avg", obs_avg, 64'd200);

        // reset asserted mid-window
        repeat (5) @(mic_rose);
        @(mic_fell);
        wait_cycles(10);
        rst = 1'b0;
        model_reset();
        vc = valid_cnt;
        repeat (3) begin
            @(negedge clk);
            check("rstmid_sum", period_sum, 64'd0);
            check("rstmid_avg", period_avg, 64'd0);
            check("rstmid_valid", {63'd0, meas_valid}, 64'd0);
            check("rstmid_timeout", {63'd0, timeout}, 64'd0);
        end
        rst = 1'b1;
        rise_cnt = 0;
        wait_valids(vc + 1, 4000, "postrst");
        check("postrst_edges", rise_at_valid, 64'd17);
        check("postrst_sum", obs_sum, 64'd3200);
        check("postrst_avg", obs_avg, 64'd200);

        // table of short periods, including the minimum legal period of 4
        for (int i = 0; i < 4; i++) begin
            stop_mic_low();
            set_enable(1'b0);
            wait_cycles(4);
            set_enable(1'b1);
            wait_cycles(4);
            vc = valid_cnt;
            start_mic(vecs[i].hi, vecs[i].lo);
            wait_valids(vc + 2, 40 * (vecs[i].hi + vecs[i].lo) + 100, "vec");
            check("vec_edges", rise_at_valid, 64'd33);
            check("vec_sum", obs_sum, vecs[i].sum);
            check("vec_avg", obs_avg, vecs[i].avg);
            check("vec_spacing", valid_cyc - prev_valid_cyc, vecs[i].spacing);
        end
        stop_mic_low();
        set_enable(1'b0);
        wait_cycles(10);
        check("sb_drained", sb_q.size(), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
